bdu_feeder: RTL and testbench

BDU_FEEDER -- requirements
Module: bdu_feeder

---
 rtl/bdu_feeder_if.sv | 46 ++++
 rtl/bdu_feeder.sv | 135 +++++++++++++
 tb/tb_bdu_feeder.sv | 365 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bdu_feeder_if.sv
// Bundle between the BDU feeder and its environment.
// Query/reference inputs come in; bit beats and per-point status go out.
interface bdu_feeder_if #(
  parameter int B     = 32,
  parameter int IDX_W = 16
);
  localparam int BW = $clog2(B + 1);

  logic             q_load;
  logic [B-1:0]     q_x;
  logic [B-1:0]     q_y;
  logic [B-1:0]     q_z;
  logic             ref_valid;
  logic             ref_ready;
  logic [B-1:0]     r_x;
  logic [B-1:0]     r_y;
  logic [B-1:0]     r_z;
  logic             bdu_complete;
  logic             bdu_output_valid;
  logic             valid;
  logic             q_bit;
  logic             r_bit;
  logic [1:0]       code;
  logic [BW-1:0]    b;
  logic             shift;
  logic             pt_done;
  logic             pt_kept;
  logic             pt_early;
  logic [IDX_W-1:0] pt_index;

  modport master (
    output q_load, q_x, q_y, q_z,
    output ref_valid, r_x, r_y, r_z,
    output bdu_complete, bdu_output_valid,
    input  ref_ready, valid, q_bit, r_bit, code, b,
    input  shift, pt_done, pt_kept, pt_early, pt_index
  );

  modport slave (
    input  q_load, q_x, q_y, q_z,
    input  ref_valid, r_x, r_y, r_z,
    input  bdu_complete, bdu_output_valid,
    output ref_ready, valid, q_bit, r_bit, code, b,
    output shift, pt_done, pt_kept, pt_early, pt_index
  );
endinterface

// File: rtl/bdu_feeder.sv
// Streams query/reference points to the BDU one bit beat at a time.
// Define FEEDER_EARLY_TERM_EN to cut a point short on bdu_complete.
module bdu_feeder #(
  parameter int B     = 32,
  parameter int IDX_W = 16
) (
  input logic       clk,
  input logic       rst,
  bdu_feeder_if.slave bus
);
  localparam int BW = $clog2(B + 1);
  localparam int JW = (B > 1) ? $clog2(B) : 1;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    FLUSH
  } state_t;

  state_t           state;
  logic             q_ok;
  logic             cut;
  logic [B-1:0]     qx, qy, qz;
  logic [B-1:0]     rx, ry, rz;
  logic [1:0]       dim;
  logic [JW-1:0]    p;
  logic [IDX_W-1:0] idx;

  logic             hs;
  logic             cut_now;
  logic             last;
  logic             beat;
  logic             flush;
  logic [B-1:0]     q_sel;
  logic [B-1:0]     r_sel;
  logic [BW-1:0]    b_cur;

`ifdef FEEDER_EARLY_TERM_EN
  assign cut_now = (state == STREAM) && bus.bdu_complete;
`else
  logic unused_bdu_complete;
  assign unused_bdu_complete = bus.bdu_complete;
  assign cut_now = 1'b0;
`endif

  // p is the bit position, counting down from the MSB
  assign hs    = bus.ref_valid && bus.ref_ready;
  assign last  = (dim == 2'd2) && (p == '0);
  assign beat  = (state == STREAM) && !cut_now;
  assign flush = (state == FLUSH);
  assign b_cur = BW'(B - int'(p));

  always_comb begin
    q_sel = qx;
    r_sel = rx;
    case (dim)
      2'd1: begin
        q_sel = qy;
        r_sel = ry;
      end
      2'd2: begin
        q_sel = qz;
        r_sel = rz;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      q_ok  <= 1'b0;
      cut   <= 1'b0;
      qx    <= '0;
      qy    <= '0;
      qz    <= '0;
      rx    <= '0;
      ry    <= '0;
      rz    <= '0;
      dim   <= '0;
      p     <= '0;
      idx   <= '0;
    end else begin
      if (state == IDLE && bus.q_load) begin
        qx   <= bus.q_x;
        qy   <= bus.q_y;
        qz   <= bus.q_z;
        q_ok <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (hs) begin
            rx    <= bus.r_x;
            ry    <= bus.r_y;
            rz    <= bus.r_z;
            dim   <= '0;
            p     <= JW'(B - 1);
            cut   <= 1'b0;
            state <= STREAM;
          end
        end
        STREAM: begin
          if (cut_now) begin
            cut   <= 1'b1;
            state <= FLUSH;
          end else if (last) begin
            state <= FLUSH;
          end else if (dim == 2'd2) begin
            dim <= '0;
            p   <= p - 1'b1;
          end else begin
            dim <= dim + 2'd1;
          end
        end
        FLUSH: begin
          idx   <= idx + 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ref_ready = (state == IDLE) && q_ok;
  assign bus.valid     = beat;
  assign bus.q_bit     = beat && q_sel[p];
  assign bus.r_bit     = beat && r_sel[p];
  assign bus.code      = beat ? dim + 2'd1 : 2'd0;
  assign bus.b         = beat ? b_cur : '0;
  assign bus.shift     = flush;
  assign bus.pt_done   = flush;
  assign bus.pt_kept   = flush && bus.bdu_output_valid;
  assign bus.pt_early  = flush && cut;
  assign bus.pt_index  = idx;
endmodule

// File: tb/tb_bdu_feeder.sv
// Directed bench for bdu_feeder (B=32, IDX_W=2).
// Early-termination expectations follow FEEDER_EARLY_TERM_EN.
module tb_bdu_feeder;
  localparam int B     = 32;
  localparam int IDX_W = 2;
  localparam int BW    = $clog2(B + 1);
  localparam int NB    = 3 * B;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  logic [2:0][B-1:0] qm;
  logic [2:0][B-1:0] rm;

  bdu_feeder_if #(.B(B), .IDX_W(IDX_W)) bus ();

  bdu_feeder #(.B(B), .IDX_W(IDX_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [B-1:0] x, y, z);
    bus.q_load = 1'b1;
    bus.q_x = x;
    bus.q_y = y;
    bus.q_z = z;
    qm = {z, y, x};
    tick();
    bus.q_load = 1'b0;
  endtask

  task automatic offer(input logic [B-1:0] x, y, z);
    logic rdy;
    int   k;
    bus.r_x = x;
    bus.r_y = y;
    bus.r_z = z;
    rm = {z, y, x};
    bus.ref_valid = 1'b1;
    rdy = 1'b0;
    k = 0;
    while (!rdy && k < 50) begin
      rdy = bus.ref_ready;
      tick();
      k++;
    end
    bus.ref_valid = 1'b0;
    if (!rdy) begin
      checks++;
      failures++;
      $display("FAIL offer_timeout: ref_ready=0 after %0d cycles, required 1", k);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    bus.bdu_output_valid = 1'b1;
    rst = 1'b1;
    tick();
    checks++;
    if (bus.ref_ready !== 1'b0) begin
      failures++;
      $display("FAIL rst_ready: got %b, required 0", bus.ref_ready);
    end
    checks++;
    if (bus.valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_valid: got %b, required 0", bus.valid);
    end
    checks++;
    if ({bus.shift, bus.pt_done, bus.pt_kept, bus.pt_early} !== 4'b0) begin
      failures++;
      $display("FAIL rst_flush: got %b, required 0000",
        {bus.shift, bus.pt_done, bus.pt_kept, bus.pt_early});
    end
    checks++;
    if ({bus.code, bus.b, bus.q_bit, bus.r_bit} !== '0) begin
      failures++;
      $display("FAIL rst_beat: code=%0d b=%0d q=%b r=%b, required 0",
        bus.code, bus.b, bus.q_bit, bus.r_bit);
    end
    checks++;
    if (bus.pt_index !== '0) begin
      failures++;
      $display("FAIL rst_index: got %0d, required 0", bus.pt_index);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_first_point();
    bus.r_x = 32'd5;
    bus.r_y = '0;
    bus.r_z = '0;
    rm = {32'd0, 32'd0, 32'd5};
    bus.ref_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (bus.ref_ready !== 1'b0 || bus.valid !== 1'b0) begin
        failures++;
        $display("FAIL noquery_ready: ready=%b valid=%b, required 0 0",
          bus.ref_ready, bus.valid);
      end
    end
    do_load(32'd5, 32'd0, 32'd0);
    checks++;
    if (bus.ref_ready !== 1'b1) begin
      failures++;
      $display("FAIL loaded_ready: got %b, required 1", bus.ref_ready);
    end
    tick();
    bus.ref_valid = 1'b0;
    for (int n = 0; n < NB; n++) begin
      checks++;
      if (bus.valid !== 1'b1 || bus.code !== 2'(n % 3 + 1) ||
          bus.b !== BW'(n / 3 + 1) ||
          bus.q_bit !== qm[n % 3][B - 1 - n / 3] ||
          bus.r_bit !== rm[n % 3][B - 1 - n / 3]) begin
        failures++;
        $display("FAIL beat%0d: v=%b code=%0d b=%0d q=%b r=%b, required 1 %0d %0d %b %b",
          n, bus.valid, bus.code, bus.b, bus.q_bit, bus.r_bit,
          n % 3 + 1, n / 3 + 1, qm[n % 3][B - 1 - n / 3], rm[n % 3][B - 1 - n / 3]);
      end
      tick();
    end
    checks++;
    if ({bus.valid, bus.shift, bus.pt_done, bus.pt_kept, bus.pt_early} !== 5'b01110 ||
        bus.pt_index !== 2'd0) begin
      failures++;
      $display("FAIL flush1: v/sh/done/kept/early=%b idx=%0d, required 01110 0",
        {bus.valid, bus.shift, bus.pt_done, bus.pt_kept, bus.pt_early}, bus.pt_index);
    end
    tick();
    checks++;
    if (bus.pt_index !== 2'd1 || bus.ref_ready !== 1'b1 || bus.pt_done !== 1'b0) begin
      failures++;
      $display("FAIL after_flush1: idx=%0d ready=%b done=%b, required 1 1 0",
        bus.pt_index, bus.ref_ready, bus.pt_done);
    end
  endtask

  task automatic test_beat_pattern();
    offer(32'h8000_0000, 32'd0, 32'd0);
    for (int n = 0; n < NB; n++) begin
      checks++;
      if (bus.r_bit !== (n == 0) || bus.code !== 2'(n % 3 + 1) ||
          bus.b !== BW'(n / 3 + 1)) begin
        failures++;
        $display("FAIL pattern%0d: r=%b code=%0d b=%0d, required %b %0d %0d",
          n, bus.r_bit, bus.code, bus.b, n == 0, n % 3 + 1, n / 3 + 1);
      end
      tick();
    end
    checks++;
    if (bus.pt_done !== 1'b1 || bus.pt_index !== 2'd1) begin
      failures++;
      $display("FAIL flush2: done=%b idx=%0d, required 1 1", bus.pt_done, bus.pt_index);
    end
    tick();
  endtask

  task automatic test_early_term();
    bus.bdu_output_valid = 1'b1;
    offer(32'hFFFF_FFFF, 32'hA5A5_A5A5, 32'h1234_5678);
    for (int n = 0; n < 10; n++) begin
      checks++;
      if (bus.valid !== 1'b1 || bus.r_bit !== rm[n % 3][B - 1 - n / 3]) begin
        failures++;
        $display("FAIL et_beat%0d: v=%b r=%b, required 1 %b",
          n, bus.valid, bus.r_bit, rm[n % 3][B - 1 - n / 3]);
      end
      tick();
    end
    bus.bdu_complete = 1'b1;
    bus.bdu_output_valid = 1'b0;
    #1;
`ifdef FEEDER_EARLY_TERM_EN
    checks++;
    if (bus.valid !== 1'b0) begin
      failures++;
      $display("FAIL et_cut_valid: got %b, required 0", bus.valid);
    end
    tick();
    bus.bdu_complete = 1'b0;
    checks++;
    if ({bus.shift, bus.pt_done, bus.pt_early, bus.pt_kept} !== 4'b1110 ||
        bus.pt_index !== 2'd2) begin
      failures++;
      $display("FAIL et_flush: sh/done/early/kept=%b idx=%0d, required 1110 2",
        {bus.shift, bus.pt_done, bus.pt_early, bus.pt_kept}, bus.pt_index);
    end
`else
    checks++;
    if (bus.valid !== 1'b1 || bus.code !== 2'd2 || bus.b !== BW'(4)) begin
      failures++;
      $display("FAIL noet_beat10: v=%b code=%0d b=%0d, required 1 2 4",
        bus.valid, bus.code, bus.b);
    end
    for (int n = 10; n < NB; n++) tick();
    bus.bdu_complete = 1'b0;
    checks++;
    if ({bus.shift, bus.pt_done, bus.pt_early, bus.pt_kept} !== 4'b1100 ||
        bus.pt_index !== 2'd2) begin
      failures++;
      $display("FAIL noet_flush: sh/done/early/kept=%b idx=%0d, required 1100 2",
        {bus.shift, bus.pt_done, bus.pt_early, bus.pt_kept}, bus.pt_index);
    end
`endif
    tick();
    bus.bdu_output_valid = 1'b1;
  endtask

  task automatic test_reset_mid();
    offer(32'h0F0F_0F0F, 32'd1, 32'd2);
    for (int n = 0; n < 40; n++) tick();
    checks++;
    if (bus.valid !== 1'b1 || bus.b !== BW'(14) || bus.code !== 2'd2) begin
      failures++;
      $display("FAIL mid_beat40: v=%b b=%0d code=%0d, required 1 14 2",
        bus.valid, bus.b, bus.code);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.valid, bus.ref_ready, bus.shift, bus.pt_done, bus.q_bit, bus.r_bit} !== 6'b0 ||
        bus.code !== 2'd0 || bus.b !== '0 || bus.pt_index !== 2'd0) begin
      failures++;
      $display("FAIL mid_async: v=%b rdy=%b sh=%b done=%b code=%0d b=%0d idx=%0d, required all 0",
        bus.valid, bus.ref_ready, bus.shift, bus.pt_done, bus.code, bus.b, bus.pt_index);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.pt_done !== 1'b0 || bus.shift !== 1'b0) begin
        failures++;
        $display("FAIL mid_nodone: done=%b shift=%b, required 0 0", bus.pt_done, bus.shift);
      end
    end
    rst = 1'b0;
    tick();
    checks++;
    if (bus.ref_ready !== 1'b0) begin
      failures++;
      $display("FAIL mid_flag: ready=%b, required 0", bus.ref_ready);
    end
    do_load(32'h8000_0000, 32'd0, 32'd0);
    offer(32'd0, 32'd0, 32'd0);
    checks++;
    if (bus.valid !== 1'b1 || bus.b !== BW'(1) || bus.code !== 2'd1 ||
        bus.q_bit !== 1'b1 || bus.pt_index !== 2'd0) begin
      failures++;
      $display("FAIL mid_restart: v=%b b=%0d code=%0d q=%b idx=%0d, required 1 1 1 1 0",
        bus.valid, bus.b, bus.code, bus.q_bit, bus.pt_index);
    end
    for (int n = 0; n < NB + 1; n++) tick();
  endtask

  task automatic test_back_to_back();
    int w;
    do_reset();
    do_load(32'd7, 32'd9, 32'd11);
    bus.r_x = 32'd7;
    bus.r_y = 32'd9;
    bus.r_z = 32'd11;
    bus.ref_valid = 1'b1;
    bus.bdu_output_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      w = 0;
      do begin
        tick();
        w++;
      end while (!bus.pt_done && w < 200);
      checks++;
      if (bus.pt_done !== 1'b1 || bus.pt_index !== 2'(k % 4) ||
          (k > 0 && w != NB + 2)) begin
        failures++;
        $display("FAIL b2b_%0d: done=%b idx=%0d gap=%0d, required 1 %0d %0d",
          k, bus.pt_done, bus.pt_index, w, k % 4, NB + 2);
      end
    end
    bus.ref_valid = 1'b0;
    tick();
  endtask

  task automatic test_load_and_offer();
    bus.q_load = 1'b1;
    bus.q_x = 32'hC000_0000;
    bus.q_y = 32'd0;
    bus.q_z = 32'd0;
    bus.r_x = '0;
    bus.r_y = '0;
    bus.r_z = '0;
    bus.ref_valid = 1'b1;
    tick();
    bus.q_load = 1'b0;
    bus.ref_valid = 1'b0;
    checks++;
    if (bus.valid !== 1'b1 || bus.q_bit !== 1'b1) begin
      failures++;
      $display("FAIL same_cycle_load: v=%b q=%b, required 1 1", bus.valid, bus.q_bit);
    end
    bus.q_load = 1'b1;
    bus.q_x = 32'd0;
    tick();
    bus.q_load = 1'b0;
    tick();
    tick();
    checks++;
    if (bus.code !== 2'd1 || bus.b !== BW'(2) || bus.q_bit !== 1'b1) begin
      failures++;
      $display("FAIL stream_load_ignored: code=%0d b=%0d q=%b, required 1 2 1",
        bus.code, bus.b, bus.q_bit);
    end
    for (int n = 3; n < NB + 1; n++) tick();
    offer(32'd0, 32'd0, 32'd0);
    checks++;
    if (bus.valid !== 1'b1 || bus.q_bit !== 1'b1) begin
      failures++;
      $display("FAIL query_persist: v=%b q=%b, required 1 1", bus.valid, bus.q_bit);
    end
  endtask

  initial begin
    rst = 1'b0;
    bus.q_load = 1'b0;
    bus.q_x = '0;
    bus.q_y = '0;
    bus.q_z = '0;
    bus.ref_valid = 1'b0;
    bus.r_x = '0;
    bus.r_y = '0;
    bus.r_z = '0;
    bus.bdu_complete = 1'b0;
    bus.bdu_output_valid = 1'b0;
    qm = '0;
    rm = '0;
    #2;
    test_reset();
    test_first_point();
    test_beat_pattern();
    test_early_term();
    test_reset_mid();
    test_back_to_back();
    test_load_and_offer();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
